// File: rtl/if_stage_if.sv
// Instruction-memory handshake bundle between the fetch stage and imem.
//   imem_req   : fetch request (fetch -> mem)
//   imem_addr  : fetch address, held stable while a request waits (fetch -> mem)
//   imem_ready : memory accepts the request this cycle (mem -> fetch)
//   imem_rdata : instruction word, valid with imem_ready (mem -> fetch)
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ready, input imem_rdata);
    modport slave  (input  imem_req, input imem_addr,
                    output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake,
// absorbs wait states, hazard freezes and branch redirects, and drives the
// IF/ID register consumed by decode.
//   clk, rst          : clock, synchronous active-high reset
//   freeze            : hazard stall, IF/ID and PC hold
//   branch_taken/addr : redirect request and target from EXE
//   imem              : instruction-memory handshake (master side)
//   Instruction/PC/valid : IF/ID register (PC is instruction address + 4)
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    if_stage_if.master  imem,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic        valid
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic [31:0] redir_pc;
    logic [31:0] pc_inc;

    assign pc_inc = pc + 32'd4;

    // The address must stay on pc during DRAIN so the outstanding request
    // completes at the address it was issued with.
    assign imem.imem_req  = !rst && (state != HOLD);
    assign imem.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            buf_instr   <= '0;
            buf_pc      <= '0;
            redir_pc    <= '0;
            Instruction <= '0;
            PC          <= '0;
            valid       <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (branch_taken) begin
                        Instruction <= '0;
                        PC          <= '0;
                        valid       <= 1'b0;
                        buf_instr   <= '0;
                        buf_pc      <= '0;
                        if (imem.imem_ready) begin
                            pc <= branch_addr;  // returned word dropped
                        end else begin
                            redir_pc <= branch_addr;
                            state    <= DRAIN;
                        end
                    end else if (imem.imem_ready) begin
                        pc <= pc_inc;
                        if (freeze) begin
                            // IF/ID is stalled: park the word until release
                            buf_instr <= imem.imem_rdata;
                            buf_pc    <= pc_inc;
                            state     <= HOLD;
                        end else begin
                            Instruction <= imem.imem_rdata;
                            PC          <= pc_inc;
                            valid       <= 1'b1;
                        end
                    end else if (!freeze) begin
                        Instruction <= '0;
                        PC          <= '0;
                        valid       <= 1'b0;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        Instruction <= '0;
                        PC          <= '0;
                        valid       <= 1'b0;
                        buf_instr   <= '0;
                        buf_pc      <= '0;
                        pc          <= branch_addr;
                        state       <= FETCH;
                    end else if (!freeze) begin
                        Instruction <= buf_instr;
                        PC          <= buf_pc;
                        valid       <= 1'b1;
                        state       <= FETCH;
                    end
                end
                DRAIN: begin
                    Instruction <= '0;
                    PC          <= '0;
                    valid       <= 1'b0;
                    if (imem.imem_ready) begin
                        // a branch arriving on the completing edge is newest
                        pc    <= branch_taken ? branch_addr : redir_pc;
                        state <= FETCH;
                    end else if (branch_taken) begin
                        redir_pc <= branch_addr;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage ARM pipeline, directly upstream of the decode stage. It owns the program counter and issues fetches over a request/ready instruction-memory handshake. It absorbs memory wait states, hazard freezes and branch redirects, and drives the IF/ID pipeline register (`Instruction`, `PC`, `valid`) that decode consumes.

## Interface
Parameters
- `RESET_PC`, default 32'h0: PC value loaded on reset.

Ports
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `freeze`  in  1  hazard stall from hazard-detect; IF/ID and PC must hold.
- `branch_taken`  in  1  redirect request from EXE.
- `branch_addr`  in  32  redirect target, valid with `branch_taken`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready`  in  1  memory accepts the request and returns `imem_rdata` in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `Instruction`  out  32  IF/ID instruction.
- `PC`  out  32  IF/ID address of the instruction + 4.
- `valid`  out  1  IF/ID holds a real instruction; 0 means bubble.

## Operation
- Internal state: `pc` (32 bits), a skid buffer (`buf_instr`, `buf_pc`), a redirect register `redir_pc`, and FSM state ∈ {FETCH, HOLD, DRAIN}.
- `imem_addr` = `pc` in FETCH and DRAIN. `imem_req` = 1 in FETCH and DRAIN and 0 in HOLD. Both are 0 and `pc` respectively while `rst`=1.
- FETCH, on `imem_ready`=1 with no branch:
  - `freeze`=0: load IF/ID with {`imem_rdata`, `pc`+4, 1}; `pc` ← `pc`+4; stay in FETCH.
  - `freeze`=1: IF/ID holds; buffer ← {`imem_rdata`, `pc`+4}; `pc` ← `pc`+4; go to HOLD.
- FETCH, on `imem_ready`=0 with no branch: if `freeze`=0, IF/ID loads a bubble {0, 0, 0}; if `freeze`=1, IF/ID holds.
- HOLD, no branch: while `freeze`=1, everything holds. When `freeze`=0, IF/ID ← buffer with valid=1, then go to FETCH.
- `branch_taken`=1 has priority over `freeze` and over any fetch completion:
  - IF/ID ← {0, 0, 0} (flush) and the buffer is discarded.
  - From FETCH with `imem_ready`=1, or from HOLD: `pc` ← `branch_addr`, go to FETCH; the returned word is dropped.
  - From FETCH with `imem_ready`=0: `redir_pc` ← `branch_addr`, go to DRAIN. `pc` is unchanged so the address stays stable.
- DRAIN:
  - IF/ID loads a bubble each cycle.
  - On `imem_ready`=1, the word is discarded, `pc` ← `redir_pc`, go to FETCH.
  - A further `branch_taken` in DRAIN overwrites `redir_pc`, and the new target wins.
- PC arithmetic is modulo 2^32: `pc`=32'hFFFFFFFC increments to 0.

## Timing
- Reset (`rst`=1 at an edge): `pc`=`RESET_PC`, state=FETCH, `Instruction`=0, `PC`=0, `valid`=0, buffer=0, `redir_pc`=0. Reset mid-DRAIN or mid-HOLD abandons all state.
- The first `imem_req`=1 is in the first cycle after `rst` deasserts.
- All outputs except `imem_req`/`imem_addr` are registered. A word accepted at edge k is visible on `Instruction` after edge k.
- Zero-wait memory with no stalls gives 1 instruction per cycle.
- Each wait cycle with `freeze`=0 inserts one bubble.
- Freeze release from HOLD: the buffered instruction appears after the first edge with `freeze`=0. The next fetch is issued in that same following cycle.
- Branch: the first target instruction reaches IF/ID at the earliest 1 cycle after the branch edge (zero wait). From DRAIN, the earliest is after the drain-completing edge plus one fetch.

## Test plan
- Reset then zero-wait memory with `imem_rdata` = `imem_addr`:
  - Response: `Instruction` = 0, 4, 8 on consecutive cycles.
  - `PC` = 4, 8, 12; `valid`=1.
- Two wait cycles on the fetch at addr 8:
  - Response: two bubbles (`valid`=0, `Instruction`=0).
  - Then `Instruction`=8, `PC`=12; `imem_addr` stays 8 throughout.
- `freeze`=1 for 3 cycles while fetching addr 4 (ready=1):
  - Response: IF/ID holds the addr-0 word, state HOLD, `imem_req`=0.
  - On release, `Instruction`=4 with `PC`=8, then fetch 8.
- `branch_taken`=1, `branch_addr`=32'h100, with `freeze`=1 and ready=1:
  - Response: IF/ID flushed next cycle.
  - `imem_addr`=32'h100; the next valid instruction has `PC`=32'h104.
- Branch to 32'h200 while the fetch at 32'h10 is waiting (ready=0 for 2 more cycles):
  - Response: `imem_addr` holds 32'h10 until ready, and that word is dropped.
  - Then `imem_addr`=32'h200; only bubbles in between.
- `pc`=32'hFFFFFFFC fetch completes → `imem_addr`=0, `PC` output = 0.
- `rst` asserted mid-DRAIN → after the edge, all outputs are 0 and `imem_addr`=`RESET_PC`.
